multi_spi_frame_rx: RTL and testbench

//   Parametrised multi-lane (x1/x2/x4) SPI receive deserialiser. Shifts lane data into a

---
 rtl/multi_spi_frame_rx_if.sv | 29 ++
 rtl/multi_spi_frame_rx.sv | 110 +++++++++++
 tb/tb_multi_spi_frame_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multi_spi_frame_rx_if.sv
// Bus bundle for the multi-lane SPI receive deserialiser: lane data, strobes,
// the word handshake and status flags.
interface multi_spi_frame_rx_if #(
   parameter int unsigned REGSIZE = 8
);
   logic [3:0]         I;
   logic [1:0]         S;
   logic               writeSelect;
   logic               sample;
   logic [REGSIZE-1:0] register;
   logic [REGSIZE-1:0] word;
   logic               word_valid;
   logic               word_ready;
   logic               busy;
   logic               overflow;
   logic               ovf_clr;

   // Driver side: pad/edge-detect logic and the word consumer
   modport master (
      output I, S, writeSelect, sample, word_ready, ovf_clr,
      input  register, word, word_valid, busy, overflow
   );

   // Receiver side
   modport slave (
      input  I, S, writeSelect, sample, word_ready, ovf_clr,
      output register, word, word_valid, busy, overflow
   );
endinterface

// File: rtl/multi_spi_frame_rx.sv
// Multi-lane (x1/x2/x4) SPI receive deserialiser. Assembles REGSIZE-bit words
// from lane data on sample strobes and hands them off through a valid/ready
// holding register, flagging words dropped while the holder is still full.
module multi_spi_frame_rx #(
   parameter int unsigned REGSIZE    = 8,
   parameter logic        SELECTCODE = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   multi_spi_frame_rx_if.slave bus
);

   localparam int unsigned     CW      = $clog2(REGSIZE + 1);
   localparam logic [CW-1:0]   LP_FULL = CW'(REGSIZE);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_count;
   logic [1:0]         r_lmode;
   logic [REGSIZE-1:0] r_register;
   logic [REGSIZE-1:0] r_word;
   logic               r_word_valid;
   logic               r_busy;
   logic               r_overflow;

   logic               w_sel;
   logic [1:0]         w_mode;
   logic [CW-1:0]      w_lanes;
   logic [3:0]         w_mask;
   logic               w_shift;
   logic [REGSIZE-1:0] w_nxt;
   logic [CW-1:0]      w_sum;
   logic               w_done;
   logic               w_load;
   logic [CW-1:0]      w_count_nxt;

   // Lane decode, next shift value and next bit count
   always_comb begin
      w_sel   = (bus.writeSelect == SELECTCODE);
      // Mode comes live from S on the first shift of a word, latched after that
      w_mode  = (r_state == ST_IDLE) ? bus.S : r_lmode;
      w_lanes = '0;
      w_mask  = '0;
      case (w_mode)
         2'b00:   begin w_lanes = CW'(1); w_mask = 4'b0001; end
         2'b01:   begin w_lanes = CW'(2); w_mask = 4'b0011; end
         2'b11:   begin w_lanes = CW'(4); w_mask = 4'b1111; end
         default: begin w_lanes = '0;     w_mask = 4'b0000; end
      endcase
      w_shift = w_sel && bus.sample && (w_lanes != '0);
      w_nxt   = (r_register << w_lanes) | REGSIZE'(bus.I & w_mask);
      w_sum   = r_count + w_lanes;
      w_done  = w_shift && (w_sum == LP_FULL);
      w_load  = !r_word_valid || bus.word_ready;
      if (w_done)
         w_count_nxt = '0;
      else if (w_shift)
         w_count_nxt = w_sum;
      else if (!w_sel)
         w_count_nxt = '0;
      else
         w_count_nxt = r_count;
   end

   // Word-assembly FSM with registered shift, handshake and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_lmode      <= '0;
         r_register   <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_busy  <= (w_count_nxt != '0);
         r_state <= (w_count_nxt != '0) ? ST_SHIFT : ST_IDLE;
         if (w_shift) begin
            r_register <= w_nxt;
            if (r_state == ST_IDLE)
               r_lmode <= bus.S;
         end
         // A completion that can load wins over a plain accept, so valid never gaps
         if (w_done && w_load) begin
            r_word       <= w_nxt;
            r_word_valid <= 1'b1;
         end else if (r_word_valid && bus.word_ready) begin
            r_word_valid <= 1'b0;
         end
         // A new drop outranks a simultaneous clear
         if (w_done && !w_load)
            r_overflow <= 1'b1;
         else if (bus.ovf_clr)
            r_overflow <= 1'b0;
      end
   end

   assign bus.register   = r_register;
   assign bus.word       = r_word;
   assign bus.word_valid = r_word_valid;
   assign bus.busy       = r_busy;
   assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_multi_spi_frame_rx.sv
// Directed self-checking bench for multi_spi_frame_rx (REGSIZE=8, SELECTCODE=0).
module tb_multi_spi_frame_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks   = 0;
   int   n_failures = 0;

   always #5 clk = ~clk;

   multi_spi_frame_rx_if #(.REGSIZE(8)) u_if ();

   multi_spi_frame_rx #(
      .REGSIZE    (8),
      .SELECTCODE (1'b0)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [3:0] d);
      u_if.I      = d;
      u_if.sample = 1'b1;
      tick();
      u_if.sample = 1'b0;
   endtask

   task automatic send_x1(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         strobe({3'b000, b[i]});
   endtask

   initial begin
      u_if.I           = '0;
      u_if.S           = 2'b00;
      u_if.writeSelect = 1'b0;
      u_if.sample      = 1'b0;
      u_if.word_ready  = 1'b1;
      u_if.ovf_clr     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_register", 32'(u_if.register), 32'h00);
      check("rst_word", 32'(u_if.word), 32'h00);
      check("rst_valid", 32'(u_if.word_valid), 32'h0);
      check("rst_busy", 32'(u_if.busy), 32'h0);
      check("rst_ovf", 32'(u_if.overflow), 32'h0);

      // 1: x1 frame 1,0,1,0,0,1,0,1
      for (int i = 7; i >= 1; i--)
         strobe({3'b000, 8'hA5 >> i});
      check("t1_busy_mid", 32'(u_if.busy), 32'h1);
      check("t1_valid_mid", 32'(u_if.word_valid), 32'h0);
      strobe(4'h1);
      check("t1_word", 32'(u_if.word), 32'hA5);
      check("t1_valid", 32'(u_if.word_valid), 32'h1);
      check("t1_busy_end", 32'(u_if.busy), 32'h0);
      tick();
      check("t1_valid_drop", 32'(u_if.word_valid), 32'h0);

      // 2: x4, then x4 with S moved to x1 after the first nibble
      u_if.S = 2'b11;
      strobe(4'hC);
      strobe(4'h3);
      check("t2_word", 32'(u_if.word), 32'hC3);
      check("t2_valid", 32'(u_if.word_valid), 32'h1);
      tick();
      u_if.S = 2'b11;
      strobe(4'hC);
      u_if.S = 2'b00;
      strobe(4'h3);
      check("t2_latch_word", 32'(u_if.word), 32'hC3);
      check("t2_latch_valid", 32'(u_if.word_valid), 32'h1);
      check("t2_latch_reg", 32'(u_if.register), 32'hC3);
      tick();
      check("t2_valid_drop", 32'(u_if.word_valid), 32'h0);

      // 3: x2 partial word, deselect, then full word of 2'b11 pairs
      u_if.S = 2'b01;
      strobe(4'h2);
      strobe(4'h2);
      check("t3_reg_part", 32'(u_if.register), 32'h3A);
      check("t3_busy_part", 32'(u_if.busy), 32'h1);
      u_if.writeSelect = 1'b1;
      strobe(4'h3);
      check("t3_busy_desel", 32'(u_if.busy), 32'h0);
      check("t3_reg_hold", 32'(u_if.register), 32'h3A);
      u_if.writeSelect = 1'b0;
      strobe(4'h3);
      strobe(4'h3);
      check("t3_no_partial", 32'(u_if.word_valid), 32'h0);
      strobe(4'h3);
      strobe(4'h3);
      check("t3_word", 32'(u_if.word), 32'hFF);
      check("t3_valid", 32'(u_if.word_valid), 32'h1);
      tick();

      // 4: overrun with word_ready low, ovf_clr, clear/new-overflow priority
      u_if.S          = 2'b00;
      u_if.word_ready = 1'b0;
      send_x1(8'h11);
      check("t4_word1", 32'(u_if.word), 32'h11);
      send_x1(8'h22);
      check("t4_word_kept", 32'(u_if.word), 32'h11);
      check("t4_ovf", 32'(u_if.overflow), 32'h1);
      check("t4_valid_kept", 32'(u_if.word_valid), 32'h1);
      u_if.ovf_clr = 1'b1;
      tick();
      check("t4_ovf_clr", 32'(u_if.overflow), 32'h0);
      send_x1(8'h33);
      check("t4_ovf_prio", 32'(u_if.overflow), 32'h1);
      tick();
      u_if.ovf_clr = 1'b0;
      check("t4_ovf_clr2", 32'(u_if.overflow), 32'h0);
      u_if.word_ready = 1'b1;
      tick();
      check("t4_valid_drop", 32'(u_if.word_valid), 32'h0);
      check("t4_word_final", 32'(u_if.word), 32'h11);

      // 5: accept and completion in the same cycle
      u_if.word_ready = 1'b0;
      send_x1(8'h5A);
      check("t5_word1", 32'(u_if.word), 32'h5A);
      for (int i = 7; i >= 1; i--)
         strobe({3'b000, 8'h96 >> i});
      check("t5_valid_hold", 32'(u_if.word_valid), 32'h1);
      u_if.word_ready = 1'b1;
      strobe(4'h0);
      check("t5_word2", 32'(u_if.word), 32'h96);
      check("t5_valid_nogap", 32'(u_if.word_valid), 32'h1);
      check("t5_ovf", 32'(u_if.overflow), 32'h0);
      tick();
      check("t5_valid_drop", 32'(u_if.word_valid), 32'h0);

      // 6: reset mid-word, fresh frame, reserved mode holds
      for (int i = 0; i < 5; i++)
         strobe(4'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_reg", 32'(u_if.register), 32'h00);
      check("t6_word", 32'(u_if.word), 32'h00);
      check("t6_valid", 32'(u_if.word_valid), 32'h0);
      check("t6_busy", 32'(u_if.busy), 32'h0);
      check("t6_ovf", 32'(u_if.overflow), 32'h0);
      send_x1(8'h3C);
      check("t6_word_new", 32'(u_if.word), 32'h3C);
      check("t6_valid_new", 32'(u_if.word_valid), 32'h1);
      u_if.S = 2'b10;
      strobe(4'hF);
      check("t6_reserved_reg", 32'(u_if.register), 32'h3C);
      check("t6_reserved_busy", 32'(u_if.busy), 32'h0);
      check("t6_reserved_word", 32'(u_if.word), 32'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
